// File: rtl/morse_encoder.sv
// Morse encoder: accepts one character code per valid/ready handshake and keys it
// out as timed marks and spaces, with one-cycle dot/dash strobes for loopback.
module morse_encoder #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] char_in,
    input  logic       valid,
    output logic       ready,
    output logic       key,
    output logic       dot,
    output logic       dash,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, MARK, SPACE, LGAP, WGAP} state_t;

    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] DOT_LEN  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LEN = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] LGAP_LEN = CW'(3 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] WGAP_LEN = CW'(4 * UNIT_CYCLES - 1);

    // Pattern is left-aligned: element i lives at bit (4-i), 1 = dash.
    function automatic logic [7:0] lookup(input logic [5:0] code);
        logic [7:0] r;
        r = '0;
        case (code)
            6'd0:  r = {3'd2, 5'b01000};
            6'd1:  r = {3'd4, 5'b10000};
            6'd2:  r = {3'd4, 5'b10100};
            6'd3:  r = {3'd3, 5'b10000};
            6'd4:  r = {3'd1, 5'b00000};
            6'd5:  r = {3'd4, 5'b00100};
            6'd6:  r = {3'd3, 5'b11000};
            6'd7:  r = {3'd4, 5'b00000};
            6'd8:  r = {3'd2, 5'b00000};
            6'd9:  r = {3'd4, 5'b01110};
            6'd10: r = {3'd3, 5'b10100};
            6'd11: r = {3'd4, 5'b01000};
            6'd12: r = {3'd2, 5'b11000};
            6'd13: r = {3'd2, 5'b10000};
            6'd14: r = {3'd3, 5'b11100};
            6'd15: r = {3'd4, 5'b01100};
            6'd16: r = {3'd4, 5'b11010};
            6'd17: r = {3'd3, 5'b01000};
            6'd18: r = {3'd3, 5'b00000};
            6'd19: r = {3'd1, 5'b10000};
            6'd20: r = {3'd3, 5'b00100};
            6'd21: r = {3'd4, 5'b00010};
            6'd22: r = {3'd3, 5'b01100};
            6'd23: r = {3'd4, 5'b10010};
            6'd24: r = {3'd4, 5'b10110};
            6'd25: r = {3'd4, 5'b11000};
            6'd26: r = {3'd5, 5'b11111};
            6'd27: r = {3'd5, 5'b01111};
            6'd28: r = {3'd5, 5'b00111};
            6'd29: r = {3'd5, 5'b00011};
            6'd30: r = {3'd5, 5'b00001};
            6'd31: r = {3'd5, 5'b00000};
            6'd32: r = {3'd5, 5'b10000};
            6'd33: r = {3'd5, 5'b11000};
            6'd34: r = {3'd5, 5'b11100};
            6'd35: r = {3'd5, 5'b11110};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [2:0]    idx, nxt_idx, len, nxt_len;
    logic [4:0]    pat, nxt_pat;
    logic [2:0]    lut_len;
    logic [4:0]    lut_pat;
    logic          accept, nxt_err, el_dash, entering_mark;

    assign ready = (state == IDLE);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path infers a latch.
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_idx   = idx;
        nxt_len   = len;
        nxt_pat   = pat;
        nxt_err   = 1'b0;
        accept    = valid && (state == IDLE);
        {lut_len, lut_pat} = lookup(char_in);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (char_in <= 6'd35) begin
                        nxt_state = MARK;
                        nxt_idx   = 3'd0;
                        nxt_len   = lut_len;
                        nxt_pat   = lut_pat;
                        nxt_cnt   = lut_pat[4] ? DASH_LEN : DOT_LEN;
                    end else if (char_in == 6'd36) begin
                        nxt_state = WGAP;
                        nxt_cnt   = WGAP_LEN;
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            MARK: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - 1'b1;
                end else if (idx == len - 3'd1) begin
                    nxt_state = LGAP;
                    nxt_cnt   = LGAP_LEN;
                end else begin
                    nxt_state = SPACE;
                    nxt_cnt   = DOT_LEN;
                end
            end
            SPACE: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - 1'b1;
                end else begin
                    nxt_state = MARK;
                    nxt_idx   = idx + 3'd1;
                    nxt_cnt   = pat[3'd3 - idx] ? DASH_LEN : DOT_LEN;
                end
            end
            LGAP, WGAP: begin
                if (cnt != '0) nxt_cnt = cnt - 1'b1;
                else           nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase

        el_dash       = nxt_pat[3'd4 - nxt_idx];
        entering_mark = (nxt_state == MARK) && (state != MARK);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            len   <= '0;
            pat   <= '0;
            key   <= 1'b0;
            dot   <= 1'b0;
            dash  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state <= nxt_state;
            cnt   <= nxt_cnt;
            idx   <= nxt_idx;
            len   <= nxt_len;
            pat   <= nxt_pat;
            key   <= (nxt_state == MARK);
            dot   <= entering_mark && !el_dash;
            dash  <= entering_mark && el_dash;
            busy  <= (nxt_state != IDLE);
            done  <= ((nxt_state == LGAP) || (nxt_state == WGAP)) && (nxt_cnt == '0);
            err   <= nxt_err;
        end
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder at UNIT_CYCLES = 4; cycle 0 is the acceptance cycle,
// per-cycle outputs are captured on the falling edge into bit vectors indexed by cycle.
module tb_morse_encoder;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [5:0] char_in;
    logic       valid;
    logic       ready, key, dot, dash, busy, done, err;

    int checks   = 0;
    int failures = 0;

    logic [127:0] key_v, dot_v, dash_v, done_v, ready_v, err_v;

    morse_encoder #(.UNIT_CYCLES(4)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .char_in(char_in),
        .valid  (valid),
        .ready  (ready),
        .key    (key),
        .dot    (dot),
        .dash   (dash),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Called while sitting at a falling edge; the code is accepted at the next rising edge.
    task automatic send(input logic [5:0] code);
        char_in = code;
        valid   = 1'b1;
        @(posedge Clock);
        #1;
        valid   = 1'b0;
        char_in = 6'd63;
    endtask

    task automatic capture(input int n);
        key_v = '0; dot_v = '0; dash_v = '0; done_v = '0; ready_v = '0; err_v = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge Clock);
            key_v[i]   = key;
            dot_v[i]   = dot;
            dash_v[i]  = dash;
            done_v[i]  = done;
            ready_v[i] = ready;
            err_v[i]   = err;
        end
    endtask

    task automatic loopback(input string tag, input logic [5:0] code, input int exp_n,
                            input logic [7:0] exp_seq);
        int         n;
        logic [7:0] seq;
        n   = 0;
        seq = '0;
        send(code);
        capture(100);
        for (int i = 1; i <= 100; i++) begin
            if (dot_v[i])  begin seq = {seq[6:0], 1'b0}; n++; end
            if (dash_v[i]) begin seq = {seq[6:0], 1'b1}; n++; end
        end
        check({tag, "_seq"}, 128'(n * 256 + int'(seq)), 128'(exp_n * 256 + int'(exp_seq)));
        check({tag, "_overlap"}, dot_v & dash_v, '0);
    endtask

    initial begin
        Reset   = 1'b1;
        valid   = 1'b0;
        char_in = 6'd0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_busy",  128'(busy),  128'(0));
        check("rst_key",   128'(key),   128'(0));
        check("rst_strobes", 128'({dot, dash, done, err}), 128'(0));

        // E: single dot
        send(6'd4);
        capture(17);
        check("E_key",   key_v,   rng(1, 4));
        check("E_dot",   dot_v,   rng(1, 1));
        check("E_dash",  dash_v,  '0);
        check("E_done",  done_v,  rng(16, 16));
        check("E_ready", ready_v, rng(17, 17));

        // T: single dash, accepted on the first ready cycle after E
        send(6'd19);
        capture(25);
        check("T_key",  key_v,  rng(1, 12));
        check("T_dash", dash_v, rng(1, 1));
        check("T_dot",  dot_v,  '0);
        check("T_done", done_v, rng(24, 24));

        // A: dot, space, dash
        send(6'd0);
        capture(33);
        check("A_key",  key_v,  rng(1, 4) | rng(9, 20));
        check("A_dot",  dot_v,  rng(1, 1));
        check("A_dash", dash_v, rng(9, 9));
        check("A_done", done_v, rng(32, 32));

        // Zero: five dashes, longest character
        send(6'd26);
        capture(89);
        check("Z0_key", key_v, rng(1, 12) | rng(17, 28) | rng(33, 44) | rng(49, 60) | rng(65, 76));
        check("Z0_dash", dash_v, rng(1, 1) | rng(17, 17) | rng(33, 33) | rng(49, 49) | rng(65, 65));
        check("Z0_dot",   dot_v,   '0);
        check("Z0_done",  done_v,  rng(88, 88));
        check("Z0_ready", ready_v, rng(89, 89));

        // Word space on the next ready
        send(6'd36);
        capture(17);
        check("WS_key",   key_v,   '0);
        check("WS_marks", dot_v | dash_v, '0);
        check("WS_done",  done_v,  rng(16, 16));
        check("WS_ready", ready_v, rng(17, 17));

        // Invalid code
        send(6'd40);
        capture(3);
        check("INV_err",   err_v,   rng(1, 1));
        check("INV_ready", ready_v, rng(1, 3));
        check("INV_key",   key_v | dot_v | dash_v | done_v, '0);

        // Invalid code held with valid high pulses err every cycle
        char_in = 6'd45;
        valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("HOLD_err", 128'(err), 128'(1));
        end
        valid = 1'b0;
        @(negedge Clock);
        check("HOLD_err_off", 128'(err), 128'(0));
        check("HOLD_ready",   128'(ready), 128'(1));

        // Reset in cycle 6 of a T, with valid asserted during reset
        send(6'd19);
        capture(5);
        @(negedge Clock);
        check("RST_key_before", 128'(key), 128'(1));
        Reset   = 1'b1;
        valid   = 1'b1;
        char_in = 6'd4;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        valid = 1'b0;
        @(negedge Clock);
        check("RST_key",   128'(key),   128'(0));
        check("RST_ready", 128'(ready), 128'(1));
        check("RST_busy",  128'(busy),  128'(0));
        capture(30);
        check("RST_no_done", done_v, '0);
        check("RST_no_key",  key_v,  '0);

        // Strobe sequences as seen by a downstream decoder
        loopback("LB_H", 6'd7,  4, 8'b0000);
        loopback("LB_S", 6'd18, 3, 8'b000);
        loopback("LB_Q", 6'd16, 4, 8'b1101);
        loopback("LB_8", 6'd34, 5, 8'b11100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
